// File: rtl/sudoku_solve_ctrl.sv
// ---------------------------------------------------------------------------
// sudoku_solve_ctrl
//   Iterative Sudoku constraint-propagation controller. A 729-bit candidate
//   mask (bit cell*9+d set = digit d+1 still allowed in that cell, with
//   cell = row*9+col) is loaded on start. The controller then alternates
//   between two steps until the grid settles:
//     EVAL   - capture the deduction datapath (sudoku_ans) into ans_q.
//     UPDATE - fold the deductions back into the working mask and classify
//              the result as solved, conflict or stalled.
//   Each EVAL/UPDATE pair costs two cycles. done pulses one cycle after
//   FINISH, so a puzzle that needs N updates reports done 2N+1 cycles after
//   the edge that accepts start.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle solve request, honoured only in IDLE
//   puzzle_in  : 729-bit candidate mask, sampled on the accepting edge
//   busy       : solve in progress (EVAL/UPDATE)
//   done       : one-cycle pulse, status and puzzle_out valid
//   solved     : every cell one-hot at termination
//   conflict   : a cell lost all candidates or got several forced digits
//   stalled    : fixed point or iteration limit reached without a solution
//   iter_count : completed UPDATE cycles for the current/last puzzle
//   puzzle_out : working mask register (final mask once done)
// ---------------------------------------------------------------------------

// Single-step deduction datapath (naked singles). For every cell, the digits
// of already-decided peers (same row, column or box) are removed from the
// cell's candidates:
//   exactly one survivor -> that digit is forced (one-hot group)
//   several survivors    -> nothing learned yet (zero group)
//   no survivor          -> contradiction, reported as every digit forced
//                           so the controller sees "multiple forced digits"
module sudoku_ans (
    input  logic [728:0] puzzle_mask_bin,
    output logic [728:0] ans_bin
);

    function automatic logic onehot9(input logic [8:0] g);
        return (g != 9'd0) && ((g & (g - 9'd1)) == 9'd0);
    endfunction

    // Groups of cells that are already decided; undecided cells contribute 0.
    logic [728:0] single;

    always_comb begin
        single = '0;
        for (int c = 0; c < 81; c++) begin
            if (onehot9(puzzle_mask_bin[c*9 +: 9])) begin
                single[c*9 +: 9] = puzzle_mask_bin[c*9 +: 9];
            end
        end
    end

    logic [8:0] seen;
    logic [8:0] elim;

    always_comb begin
        ans_bin = '0;
        seen    = '0;
        elim    = '0;
        for (int c = 0; c < 81; c++) begin
            seen = '0;
            for (int p = 0; p < 81; p++) begin
                if ((p != c) &&
                    ((p / 9 == c / 9) ||
                     (p % 9 == c % 9) ||
                     ((p / 27 == c / 27) && ((p % 9) / 3 == (c % 9) / 3)))) begin
                    seen = seen | single[p*9 +: 9];
                end
            end
            elim = puzzle_mask_bin[c*9 +: 9] & ~seen;
            if (onehot9(elim)) begin
                ans_bin[c*9 +: 9] = elim;
            end else if (elim == 9'd0) begin
                ans_bin[c*9 +: 9] = 9'h1FF;
            end else begin
                ans_bin[c*9 +: 9] = 9'h000;
            end
        end
    end

endmodule

module sudoku_solve_ctrl #(
    parameter int MAX_ITER = 81,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [728:0]     puzzle_in,
    output logic             busy,
    output logic             done,
    output logic             solved,
    output logic             conflict,
    output logic             stalled,
    output logic [CNT_W-1:0] iter_count,
    output logic [728:0]     puzzle_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    function automatic logic onehot9(input logic [8:0] g);
        return (g != 9'd0) && ((g & (g - 9'd1)) == 9'd0);
    endfunction

    state_t             state_q, state_d;
    logic [728:0]       mask_q, mask_d;
    logic [728:0]       ans_q, ans_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               solved_q, solved_d;
    logic               conflict_q, conflict_d;
    logic               stalled_q, stalled_d;

    logic [728:0]       dp_ans;

    sudoku_ans u_ans (
        .puzzle_mask_bin (mask_q),
        .ans_bin         (dp_ans)
    );

    // Fold registered deductions into the mask. A group with several forced
    // digits keeps its current mask; the conflict flag covers it.
    logic [728:0] next_mask;
    logic         any_multi;
    logic         any_zero;
    logic         all_onehot;

    always_comb begin
        next_mask  = '0;
        any_multi  = 1'b0;
        any_zero   = 1'b0;
        all_onehot = 1'b1;
        for (int g = 0; g < 81; g++) begin
            if (onehot9(ans_q[g*9 +: 9])) begin
                next_mask[g*9 +: 9] = ans_q[g*9 +: 9];
            end else begin
                next_mask[g*9 +: 9] = mask_q[g*9 +: 9];
            end
            if ((ans_q[g*9 +: 9] != 9'd0) && !onehot9(ans_q[g*9 +: 9])) begin
                any_multi = 1'b1;
            end
            if (next_mask[g*9 +: 9] == 9'd0) begin
                any_zero = 1'b1;
            end
            if (!onehot9(next_mask[g*9 +: 9])) begin
                all_onehot = 1'b0;
            end
        end
    end

    // Saturating increment; the limit check uses the unsaturated count.
    logic [CNT_W-1:0] iter_inc;
    logic             last_iter;

    assign iter_inc  = (&iter_q) ? iter_q : iter_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_iter = ((int'(iter_q) + 1) == MAX_ITER);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ans_d      = ans_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        solved_d   = solved_q;
        conflict_d = conflict_q;
        stalled_d  = stalled_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d     = puzzle_in;
                    iter_d     = '0;
                    solved_d   = 1'b0;
                    conflict_d = 1'b0;
                    stalled_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_EVAL;
                end
            end
            S_EVAL: begin
                ans_d   = dp_ans;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                mask_d  = next_mask;
                iter_d  = iter_inc;
                busy_d  = 1'b0;
                state_d = S_FINISH;
                if (any_multi || any_zero) begin
                    conflict_d = 1'b1;
                end else if (all_onehot) begin
                    solved_d = 1'b1;
                end else if (next_mask == mask_q) begin
                    stalled_d = 1'b1;
                end else if (last_iter) begin
                    stalled_d = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_FINISH: begin
                // done rises on the edge that leaves FINISH
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            ans_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            solved_q   <= 1'b0;
            conflict_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ans_q      <= ans_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            solved_q   <= solved_d;
            conflict_q <= conflict_d;
            stalled_q  <= stalled_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign solved     = solved_q;
    assign conflict   = conflict_q;
    assign stalled    = stalled_q;
    assign iter_count = iter_q;
    assign puzzle_out = mask_q;

endmodule

// File: tb/tb_sudoku_solve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sudoku_solve_ctrl
//   Directed bench for sudoku_solve_ctrl. A table of puzzles with
//   hand-derived expected status, latency, iteration count and final mask,
//   followed by hand-written sequences for reset, held start and late
//   puzzle_in changes. The reference grid is the pattern
//   digit(r,c) = ((3*(r%3) + r/3 + c) % 9) + 1.
// ---------------------------------------------------------------------------
module tb_sudoku_solve_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [728:0] puzzle_in;
    logic         busy;
    logic         done;
    logic         solved;
    logic         conflict;
    logic         stalled;
    logic [6:0]   iter_count;
    logic [728:0] puzzle_out;

    int checks   = 0;
    int failures = 0;

    sudoku_solve_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .puzzle_in  (puzzle_in),
        .busy       (busy),
        .done       (done),
        .solved     (solved),
        .conflict   (conflict),
        .stalled    (stalled),
        .iter_count (iter_count),
        .puzzle_out (puzzle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [728:0] pin;
        int           lat;
        logic         sol;
        logic         con;
        logic         stl;
        int           iter;
        logic [728:0] pout;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [728:0] pin, input int lat,
                                input logic sol, input logic con, input logic stl,
                                input int it, input logic [728:0] pout);
        vec_t v;
        v.name = n;
        v.pin  = pin;
        v.lat  = lat;
        v.sol  = sol;
        v.con  = con;
        v.stl  = stl;
        v.iter = it;
        v.pout = pout;
        return v;
    endfunction

    function automatic logic [8:0] digit(input int d);
        logic [8:0] x;
        x = '0;
        x[d-1] = 1'b1;
        return x;
    endfunction

    function automatic logic [728:0] set_cell(input logic [728:0] m, input int r,
                                              input int c, input logic [8:0] g);
        logic [728:0] t;
        t = m;
        t[(r*9+c)*9 +: 9] = g;
        return t;
    endfunction

    function automatic logic [728:0] grid_g();
        logic [728:0] m;
        m = '0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                m = set_cell(m, r, c, digit(((3*(r%3) + r/3 + c) % 9) + 1));
            end
        end
        return m;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkm(input string name, input logic [728:0] act, input logic [728:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one puzzle, then count edges until done appears.
    task automatic run_case(input vec_t v);
        int n;
        bit seen;
        puzzle_in = v.pin;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk1({v.name, "_busy"}, busy, 1'b1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        chkn({v.name, "_latency"}, seen ? n : -1, v.lat);
        chk1({v.name, "_solved"}, solved, v.sol);
        chk1({v.name, "_conflict"}, conflict, v.con);
        chk1({v.name, "_stalled"}, stalled, v.stl);
        chkn({v.name, "_iter"}, int'(iter_count), v.iter);
        chkm({v.name, "_puzzle_out"}, puzzle_out, v.pout);
        tick();
        chk1({v.name, "_done_one_cycle"}, done, 1'b0);
    endtask

    vec_t         vecs[6];
    logic [728:0] g_grid;
    logic [728:0] chain;
    logic [728:0] ones;

    initial begin
        int  cnt;
        bit  prev;
        bit  dbl;
        logic b4;

        g_grid = grid_g();
        ones   = '1;
        // (0,0) and (8,1) resolve on the first pass; (0,1) keeps {1,2}
        // until (0,0) is decided, so it resolves on the second pass.
        chain  = set_cell(set_cell(set_cell(g_grid, 0, 0, 9'h1FF), 0, 1, 9'h1FF), 8, 1, 9'h1FF);

        vecs[0] = mk("full_grid",  g_grid, 3, 1'b1, 1'b0, 1'b0, 1, g_grid);
        vecs[1] = mk("one_blank",  set_cell(g_grid, 4, 4, 9'h1FF), 3, 1'b1, 1'b0, 1'b0, 1, g_grid);
        vecs[2] = mk("two_pass",   chain, 5, 1'b1, 1'b0, 1'b0, 2, g_grid);
        vecs[3] = mk("zero_cell",  set_cell(g_grid, 4, 4, 9'h000), 3, 1'b0, 1'b1, 1'b0, 1,
                     set_cell(g_grid, 4, 4, 9'h000));
        vecs[4] = mk("all_ones",   ones, 3, 1'b0, 1'b0, 1'b1, 1, ones);
        vecs[5] = mk("duplicate",  set_cell(g_grid, 0, 0, digit(2)), 3, 1'b0, 1'b1, 1'b0, 1,
                     set_cell(g_grid, 0, 0, digit(2)));

        // Reset state
        rst       = 1'b1;
        start     = 1'b0;
        puzzle_in = g_grid;
        tick();
        tick();
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_solved", solved, 1'b0);
        chk1("reset_conflict", conflict, 1'b0);
        chk1("reset_stalled", stalled, 1'b0);
        chkn("reset_iter", int'(iter_count), 0);
        chkm("reset_puzzle_out", puzzle_out, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i]);
        end

        // Reset during the second EVAL: outputs clear at once, no done.
        puzzle_in = chain;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chkn("pre_rst_iter", int'(iter_count), 1);
        #2;
        rst = 1'b1;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_solved", solved, 1'b0);
        chkn("midrst_iter", int'(iter_count), 0);
        chkm("midrst_puzzle_out", puzzle_out, '0);
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) cnt++;
        end
        chkn("midrst_no_done", cnt, 0);
        run_case(vecs[0]);

        // start held high and puzzle_in changed while busy: no effect.
        puzzle_in = chain;
        start     = 1'b1;
        tick();
        puzzle_in = ones;
        tick();
        chk1("held_busy_e1", busy, 1'b1);
        tick();
        tick();
        tick();
        chk1("finish_busy_low", busy, 1'b0);
        chk1("finish_no_done_yet", done, 1'b0);
        tick();
        chk1("late_in_done", done, 1'b1);
        chk1("late_in_solved", solved, 1'b1);
        chkn("late_in_iter", int'(iter_count), 2);
        chkm("late_in_puzzle_out", puzzle_out, g_grid);
        start = 1'b0;
        tick();
        chk1("late_in_done_cleared", done, 1'b0);
        chk1("late_in_idle_busy", busy, 1'b0);

        // start held through whole solves: one solve per IDLE visit.
        puzzle_in = g_grid;
        start     = 1'b1;
        tick();
        cnt  = 0;
        prev = 1'b0;
        dbl  = 1'b0;
        b4   = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (done) cnt++;
            if (done && prev) dbl = 1'b1;
            prev = done;
            if (k == 4) b4 = busy;
        end
        start = 1'b0;
        chkn("held_done_count", cnt, 2);
        chk1("held_done_width", dbl, 1'b0);
        chk1("held_restart_busy", b4, 1'b1);
        chk1("held_last_solved", solved, 1'b1);
        tick();
        chk1("held_end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
